// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the mux4 scan sequencer.
//   state_e     : FSM state encoding (IDLE, SETTLE, SAMPLE)
//   chan_t      : 2-bit mux select / channel index
//   CH_A..CH_D  : channel select codes, {S1,S0}
//   lowest_chan : lowest enabled channel of a 4-bit channel mask
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10
  } state_e;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_A = 2'b00;
  localparam chan_t CH_B = 2'b01;
  localparam chan_t CH_C = 2'b10;
  localparam chan_t CH_D = 2'b11;

  // Returns CH_A for an empty mask; callers never start a scan with one.
  function automatic chan_t lowest_chan(input logic [3:0] mask);
    chan_t c;
    c = CH_A;
    // Descending walk so the lowest set bit is the last one written.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        c = chan_t'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Bundle of the sequencer's control, data and status signals.
//   start, stop, continuous, chan_mask, dwell : scan control from the host
//   mux_out                                   : output of the downstream 4:1 mux
//   S0, S1                                    : mux select to the downstream mux
//   sample, sample_valid, busy                : frame result and status
// master: host/mux side.  slave: the sequencer.
interface mux4_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 4
);

  logic               start;
  logic               stop;
  logic               continuous;
  logic [3:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic               S0;
  logic               S1;
  logic [3:0]         sample;
  logic               sample_valid;
  logic               busy;

  modport master (
    output start, stop, continuous, chan_mask, dwell, mux_out,
    input  S0, S1, sample, sample_valid, busy
  );

  modport slave (
    input  start, stop, continuous, chan_mask, dwell, mux_out,
    output S0, S1, sample, sample_valid, busy
  );

endinterface

// File: rtl/mux4_scan_next_chan.sv
// Combinational channel walker for the scan sequencer.
//   mask       : latched channel-enable mask (bit0=A .. bit3=D)
//   cur        : channel currently being scanned
//   next_chan  : next enabled channel above cur (no wrap; holds cur when none)
//   last       : no enabled channel above cur
//   first_chan : lowest enabled channel of mask
module mux4_scan_next_chan
  import mux4_scan_pkg::*;
(
  input  logic [3:0] mask,
  input  chan_t      cur,
  output chan_t      next_chan,
  output logic       last,
  output chan_t      first_chan
);

  always_comb begin
    next_chan = cur;
    last      = 1'b1;
    // Descending walk: the closest enabled channel above cur is written last.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next_chan = chan_t'(i);
        last      = 1'b0;
      end
    end
  end

  assign first_chan = lowest_chan(mask);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux built from 2:1 muxes. Steps the mux select through the
// enabled channels, lets each settle for dwell cycles, samples mux_out for one cycle,
// and publishes each completed 4-bit frame with a one-cycle valid strobe.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of mux4_scan_ctrl_if (control in, mux_out in, select/frame/status out)
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input logic             clk,
  input logic             rst,
  mux4_scan_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  chan_t              chan_q, chan_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         sample_q, sample_d;
  logic               valid_q, valid_d;

  chan_t              next_chan;
  chan_t              first_chan;
  logic               last_chan;
  logic [3:0]         frame;

  mux4_scan_next_chan u_next_chan (
    .mask       (mask_q),
    .cur        (chan_q),
    .next_chan  (next_chan),
    .last       (last_chan),
    .first_chan (first_chan)
  );

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    frame    = shadow_q;

    unique case (state_q)
      IDLE: begin
        chan_d = CH_A;
        // stop beats start; an empty mask never leaves IDLE.
        if (bus.start && !bus.stop && (bus.chan_mask != 4'b0000)) begin
          state_d  = SETTLE;
          mask_d   = bus.chan_mask;
          dwell_d  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          cont_d   = bus.continuous;
          shadow_d = 4'b0000;
          chan_d   = lowest_chan(bus.chan_mask);
          cnt_d    = '0;
        end
      end

      SETTLE: begin
        if (bus.stop) begin
          state_d = IDLE;
          chan_d  = CH_A;
        end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      SAMPLE: begin
        if (bus.stop) begin
          // Aborted frame: nothing captured, published sample left alone.
          state_d = IDLE;
          chan_d  = CH_A;
        end else begin
          frame         = shadow_q;
          frame[chan_q] = bus.mux_out;
          shadow_d      = frame;
          cnt_d         = '0;
          if (!last_chan) begin
            chan_d  = next_chan;
            state_d = SETTLE;
          end else begin
            sample_d = frame;
            valid_d  = 1'b1;
            if (cont_q) begin
              // Back-to-back frames with no idle gap.
              shadow_d = 4'b0000;
              chan_d   = first_chan;
              state_d  = SETTLE;
            end else begin
              chan_d  = CH_A;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        chan_d  = CH_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      chan_q   <= CH_A;
      cnt_q    <= '0;
      dwell_q  <= DWELL_W'(1);
      mask_q   <= 4'b0000;
      cont_q   <= 1'b0;
      shadow_q <= 4'b0000;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  // chan_q is forced to CH_A whenever the FSM is IDLE, so select reads 00 there.
  assign bus.S1           = chan_q[1];
  assign bus.S0           = chan_q[0];
  assign bus.busy         = (state_q != IDLE);
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequencer that sits directly upstream of the 4:1 mux built from 2:1 muxes. It drives the mux select lines S1/S0 through a programmable set of channels (A..D). For each channel it waits a settle time, then samples the mux output. Completed 4-bit frames are presented with a one-cycle valid strobe, in single-shot or continuous mode.

## Interface
- DWELL_W, 4, width of the dwell (settle-cycle) input
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a scan; sampled only in IDLE
- stop  input  1  abort scan; return to IDLE next edge
- continuous  input  1  1 = restart a frame immediately after each completed frame; latched at start
- chan_mask  input  4  channel enable: bit0=A, bit1=B, bit2=C, bit3=D; latched at start
- dwell  input  DWELL_W  settle cycles per channel; 0 treated as 1; latched at start
- mux_out  input  1  output of the downstream 4:1 mux
- S0  output  1  mux select LSB
- S1  output  1  mux select MSB; {S1,S0}: 00=A, 01=B, 10=C, 11=D
- sample  output  4  last completed frame; bit i = captured mux_out for channel i; masked channels read 0
- sample_valid  output  1  one-cycle pulse when `sample` updates
- busy  output  1  high whenever not IDLE

## Operation
- Reset values: state IDLE, {S1,S0}=00, sample=0000, sample_valid=0, busy=0, internal shadow frame=0000.
- States:
  - IDLE: select held at 00.
  - SETTLE: select = current channel; counter runs.
  - SAMPLE: select = current channel; one cycle.
- IDLE → SETTLE when start=1, stop=0 and chan_mask≠0.
  - At that edge: latch mask, dwell_eff and continuous; clear the shadow frame; select the lowest enabled channel; counter=0.
  - start with chan_mask=0000 is ignored and the block stays IDLE.
- SETTLE → SAMPLE at the edge where counter==dwell_eff−1, otherwise counter+1. dwell_eff = (dwell==0) ? 1 : dwell, using DWELL_W-bit compare.
- SAMPLE, at its closing edge, writes mux_out into shadow[current channel], then:
  - If the current channel is not the highest enabled channel: go to the next enabled channel (ascending), SETTLE, counter=0.
  - If it is the highest enabled channel:
    - sample ← shadow with this bit merged in; sample_valid=1 for the following cycle.
    - If continuous: clear shadow, go to the lowest enabled channel, SETTLE. No idle gap.
    - Otherwise: go to IDLE, select=00, busy=0 on the same edge.
- stop=1 in any non-IDLE state: IDLE on the next edge, select=00, sample unchanged, no sample_valid. stop and start together: stop wins. stop in IDLE: no effect.
- start while busy: ignored. Changes to chan_mask, dwell or continuous while busy: ignored until the next start.
- Only SAMPLE captures mux_out. The select never changes during a SAMPLE cycle.

## Timing
- Start sampled at edge E0. Select is valid from E0 onward (one cycle after start is asserted).
- Per enabled channel: dwell_eff SETTLE cycles + 1 SAMPLE cycle.
- Frame of N enabled channels completes at edge E(N·(dwell_eff+1)). sample and sample_valid are registered outputs, visible in the cycle after that edge.
- Continuous mode: consecutive sample_valid pulses are exactly N·(dwell_eff+1) cycles apart.
- rst mid-scan: all outputs return to reset values immediately (asynchronously), regardless of clk.

## Structure
- Package mux4_scan_pkg holds:
  - state encoding constants: IDLE, SETTLE, SAMPLE.
  - channel select constants: CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11.
- One combinational sub-module, mux4_scan_next_chan. It takes the latched mask and the current channel and returns:
  - next enabled channel above current (no wrap)
  - a "last" flag (no higher enabled channel)
  - the lowest enabled channel
- The top level holds the FSM, the dwell counter, the shadow and sample registers, and the select drive. It instantiates the real 4:1 mux in the bench only.

## Test plan
- Reset then idle: rst pulse, start=0 → S1S0=00, sample=0000, busy=0, sample_valid=0 for 20 cycles.
- Single-shot all channels: mask=1111, dwell=2, continuous=0, mux inputs A=1 B=0 C=1 D=0.
  - S1S0 steps 00,01,10,11, 3 cycles each.
  - sample_valid pulses once, cycle after E12, with sample=0101.
  - busy=0 afterward.
- Sparse mask, dwell=0: mask=1010, dwell=0, B=1, D=1 → select only 01 then 11, 2 cycles each. sample=1010 valid after E4. Bits 0 and 2 read 0.
- Continuous: mask=0001, dwell=3, A toggled between frames → sample_valid every 4 cycles; each sample tracks A; S1S0 stays 00.
- Abort: stop asserted while in SETTLE of channel C on a full-mask scan → IDLE next edge, select 00, no sample_valid, sample keeps the previous frame. start with mask=0000 → remains IDLE.
- Async reset mid-frame: rst rises between clock edges during SAMPLE → outputs reset immediately. After release, a fresh start produces a correct full frame.
